// File: rtl/i2s_sample_sink.sv
// i2s_sample_sink: takes one sample per frame from the source and sends it on both
// channels of a Philips I2S stream, with bclk and lrclk divided down from mclk.
module i2s_sample_sink #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int CLK_DIV     = 4
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic signed [SAMPLE_BITS-1:0] p_sample_buffer,
  input  logic                          valid,
  output logic                          sample_req,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [7:0]                    underrun_cnt
);
  localparam int FRAME_LEN = 2 * SLOT_BITS * CLK_DIV;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = CW - DW;
  localparam int KW = $clog2(SLOT_BITS);
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   w_wrap, w_lr, r_fresh;
  logic [BW-1:0]          w_b;
  logic [KW-1:0]          w_k;
  logic [SAMPLE_BITS-1:0] r_shreg, r_hold, w_shreg_nxt;
  logic [SLOT_BITS-1:0]   w_slot;
  assign w_wrap      = r_cnt == CW'(FRAME_LEN - 1);
  assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_b         = w_cnt_nxt[CW-1:DW];
  assign w_lr        = w_b >= BW'(SLOT_BITS);
  assign w_k         = KW'(w_lr ? w_b - BW'(SLOT_BITS) : w_b);
  assign w_shreg_nxt = w_wrap ? r_hold : r_shreg;
  // Slot k carries sample bit SAMPLE_BITS-k, so the MSB lags lrclk by one bclk.
  assign w_slot[0] = 1'b0;
  for (genvar g = 1; g <= SAMPLE_BITS; g++) begin : g_slot
    assign w_slot[g] = w_shreg_nxt[SAMPLE_BITS-g];
  end
  if (SLOT_BITS > SAMPLE_BITS + 1) begin : g_pad
    assign w_slot[SLOT_BITS-1:SAMPLE_BITS+1] = '0;
  end
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_hold       <= '0;
      r_fresh      <= 1'b0;
      underrun_cnt <= '0;
      sample_req   <= 1'b0;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      sdata        <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      sample_req <= w_wrap;
      bclk       <= w_cnt_nxt[DW-1];
      lrclk      <= w_lr;
      sdata      <= w_slot[w_k];
      if (valid) r_hold <= p_sample_buffer;
      // A valid on the load edge keeps fresh set for the following frame.
      r_fresh <= valid | (r_fresh & ~w_wrap);
      if (w_wrap && !r_fresh && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_i2s_sample_sink.sv
// tb_i2s_sample_sink: directed frame-by-frame checks of the I2S sink.
module tb_i2s_sample_sink;
  logic        mclk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [15:0] din = '0;
  logic        sample_req, bclk, lrclk, sdata;
  logic [7:0]  underrun_cnt;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {
    int          p1;
    logic [15:0] d1;
    int          p2;
    logic [15:0] d2;
    logic [15:0] exp_s;
    logic [7:0]  exp_ur;
  } row_t;
  row_t rows[8];
  always #5 mclk = ~mclk;
  i2s_sample_sink dut (
    .mclk(mclk), .rst(rst), .p_sample_buffer(din), .valid(valid),
    .sample_req(sample_req), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .underrun_cnt(underrun_cnt)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Entered on the falling edge where cnt=0; leaves at the next such point.
  task automatic cap(input int p1, input logic [15:0] d1, input int p2, input logic [15:0] d2,
                     output logic [15:0] l, output logic [15:0] r, output int other, output int clkerr);
    logic v[256];
    logic [7:0] cc;
    other = 0;
    clkerr = 0;
    for (int c = 0; c < 256; c++) begin
      cc = 8'(c);
      if (c == p1) begin valid = 1'b1; din = d1; end
      else if (c == p2) begin valid = 1'b1; din = d2; end
      else valid = 1'b0;
      v[c] = sdata;
      if (bclk !== cc[1] || lrclk !== cc[7] || sample_req !== (c == 0)) clkerr++;
      if ((((c >> 2) % 32) == 0 || ((c >> 2) % 32) > 16) && sdata !== 1'b0) other++;
      @(negedge mclk);
    end
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      l[15-i] = v[4*(i+1)+2];
      r[15-i] = v[128+4*(i+1)+2];
    end
  endtask
  task automatic run_row(input row_t rw, input string tag);
    logic [15:0] l, r;
    int other, clkerr;
    cap(rw.p1, rw.d1, rw.p2, rw.d2, l, r, other, clkerr);
    chk({tag, "_left"}, l, rw.exp_s);
    chk({tag, "_right"}, r, rw.exp_s);
    chk({tag, "_pad_zero"}, other, 0);
    chk({tag, "_clocks"}, clkerr, 0);
    chk({tag, "_underrun"}, underrun_cnt, rw.exp_ur);
  endtask
  task automatic post_reset(input logic [15:0] s);
    int nz, rq;
    rst = 1'b1;
    valid = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst_outs", {23'b0, sample_req, bclk, lrclk, sdata, underrun_cnt}, 0);
    rst = 1'b0;
    nz = 0;
    rq = 0;
    for (int c = 0; c < 256; c++) begin
      if (c == 10) begin valid = 1'b1; din = s; end else valid = 1'b0;
      if (sdata !== 1'b0) nz++;
      if (sample_req !== 1'b0) rq++;
      @(negedge mclk);
    end
    valid = 1'b0;
    chk("frame1_zero", nz, 0);
    chk("req_early", rq, 0);
    chk("first_req", sample_req, 1);
    chk("ur_after_first_load", underrun_cnt, 0);
  endtask
  initial begin
    logic [15:0] l, r;
    int other, clkerr, bad;
    rows[0] = '{50, 16'h1234, -1, 16'h0, 16'h8001, 8'd0};
    rows[1] = '{-1, 16'h0, -1, 16'h0, 16'h1234, 8'd1};
    rows[2] = '{-1, 16'h0, -1, 16'h0, 16'h1234, 8'd2};
    rows[3] = '{20, 16'h0001, 100, 16'h7FFF, 16'h8001, 8'd0};
    rows[4] = '{-1, 16'h0, -1, 16'h0, 16'h7FFF, 8'd1};
    rows[5] = '{255, 16'hAAAA, -1, 16'h0, 16'h7FFF, 8'd2};
    rows[6] = '{-1, 16'h0, -1, 16'h0, 16'h7FFF, 8'd2};
    rows[7] = '{-1, 16'h0, -1, 16'h0, 16'hAAAA, 8'd3};
    post_reset(16'h8001);
    for (int i = 0; i < 3; i++) run_row(rows[i], $sformatf("row%0d", i));
    bad = 0;
    for (int f = 0; f < 253; f++) begin
      cap(-1, 16'h0, -1, 16'h0, l, r, other, clkerr);
      if (l !== 16'h1234 || r !== 16'h1234 || other != 0 || clkerr != 0) bad++;
    end
    chk("starved_frames", bad, 0);
    chk("ur_reach_255", underrun_cnt, 255);
    cap(-1, 16'h0, -1, 16'h0, l, r, other, clkerr);
    chk("sat_left", l, 16'h1234);
    chk("ur_saturated", underrun_cnt, 255);
    repeat (77) @(negedge mclk);
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", {23'b0, sample_req, bclk, lrclk, sdata, underrun_cnt}, 0);
    post_reset(16'h8001);
    for (int i = 3; i < 8; i++) run_row(rows[i], $sformatf("row%0d", i));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
